// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
// State codes, control bundle and opcode constants.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MDWAIT  = 2'd1,
    ST_MDDRAIN = 2'd2,
    ST_BAD     = 2'd3
  } state_t;

  localparam logic [6:0] OPC_LOAD = 7'b0000011;

  typedef struct packed {
    logic hold_pc;
    logic hold_ifid;
    logic hold_idex;
    logic bub_idex;
    logic bub_exmem;
    logic fl_ifid;
    logic fl_idex;
    logic fl_exmem;
    logic md_start;
    logic md_abort;
  } ctl_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use comparator between IF/ID sources and ID/EX load rd.
// Pure combinational; shared with the formal checks.
module hazard_detect (
  input  logic [4:0] iIF_ID_rs1,
  input  logic [4:0] iIF_ID_rs2,
  input  logic       iUsesRs1,
  input  logic       iUsesRs2,
  input  logic [4:0] iID_EX_rd,
  input  logic       iID_EX_MemRead,
  output logic       oHazard
);

  logic m1;
  logic m2;

  // A load to x0 never produces a value to wait for
  always_comb begin
    m1 = iUsesRs1 && (iIF_ID_rs1 == iID_EX_rd);
    m2 = iUsesRs2 && (iIF_ID_rs2 == iID_EX_rd);
    oHazard = iID_EX_MemRead && (iID_EX_rd != 5'd0)
              && (m1 || m2);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Load-use bubbles, redirect flushes, mul/div handshake, perf counters.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int MD_TIMEOUT = 64
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic [4:0]       iIF_ID_rs1,
  input  logic [4:0]       iIF_ID_rs2,
  input  logic             iUsesRs1,
  input  logic             iUsesRs2,
  input  logic [4:0]       iID_EX_rd,
  input  logic             iID_EX_MemRead,
  input  logic             iID_EX_MulDiv,
  input  logic             iRedirect,
  input  logic             iMdDone,
  output logic             oHoldPC,
  output logic             oHoldIFID,
  output logic             oHoldIDEX,
  output logic             oBubbleIDEX,
  output logic             oBubbleEXMEM,
  output logic             oFlushIFID,
  output logic             oFlushIDEX,
  output logic             oFlushEXMEM,
  output logic             oMdStart,
  output logic             oMdAbort,
  output logic             oMdErr,
  output logic [1:0]       oState,
  output logic [CNT_W-1:0] oStallCnt,
  output logic [CNT_W-1:0] oFlushCnt
);

  localparam int TW = $clog2(MD_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(MD_TIMEOUT - 1);

  state_t        st;
  state_t        st_nx;
  ctl_t          c;
  logic          hz;
  logic          to_hit;
  logic [TW-1:0] tcnt;

  hazard_detect u_hd (
    .iIF_ID_rs1     (iIF_ID_rs1),
    .iIF_ID_rs2     (iIF_ID_rs2),
    .iUsesRs1       (iUsesRs1),
    .iUsesRs2       (iUsesRs2),
    .iID_EX_rd      (iID_EX_rd),
    .iID_EX_MemRead (iID_EX_MemRead),
    .oHazard        (hz)
  );

  // Next state and pipeline enables; redirect overrides everything
  always_comb begin
    c      = '0;
    st_nx  = st;
    to_hit = 1'b0;
    if (iRedirect) begin
      c.fl_ifid  = 1'b1;
      c.fl_idex  = 1'b1;
      c.fl_exmem = 1'b1;
      c.md_abort = (st == ST_MDWAIT);
      st_nx      = ST_RUN;
    end else begin
      case (st)
        ST_RUN: begin
          if (iID_EX_MulDiv) begin
            c.md_start = 1'b1;
            st_nx      = ST_MDWAIT;
          end else if (hz) begin
            c.hold_pc   = 1'b1;
            c.hold_ifid = 1'b1;
            c.bub_idex  = 1'b1;
          end
        end
        ST_MDWAIT: begin
          if (iMdDone) begin
            st_nx = ST_MDDRAIN;
          end else begin
            c.hold_pc   = 1'b1;
            c.hold_ifid = 1'b1;
            c.hold_idex = 1'b1;
            c.bub_exmem = 1'b1;
            if (tcnt == TO_LAST) begin
              c.md_abort = 1'b1;
              to_hit     = 1'b1;
              st_nx      = ST_RUN;
            end
          end
        end
        ST_MDDRAIN: st_nx = ST_RUN;
        default:    st_nx = ST_RUN;
      endcase
    end
  end

  // State, timeout counter, sticky error and perf counters
  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      st        <= ST_RUN;
      tcnt      <= '0;
      oMdErr    <= 1'b0;
      oStallCnt <= '0;
      oFlushCnt <= '0;
    end else begin
      st <= st_nx;
      if (st == ST_MDWAIT) tcnt <= tcnt + TW'(1);
      else                 tcnt <= '0;
      if (to_hit) oMdErr <= 1'b1;
      if (c.hold_pc) oStallCnt <= oStallCnt + CNT_W'(1);
      if (iRedirect) oFlushCnt <= oFlushCnt + CNT_W'(1);
    end
  end

  assign oHoldPC      = c.hold_pc;
  assign oHoldIFID    = c.hold_ifid;
  assign oHoldIDEX    = c.hold_idex;
  assign oBubbleIDEX  = c.bub_idex;
  assign oBubbleEXMEM = c.bub_exmem;
  assign oFlushIFID   = c.fl_ifid;
  assign oFlushIDEX   = c.fl_idex;
  assign oFlushEXMEM  = c.fl_exmem;
  assign oMdStart     = c.md_start;
  assign oMdAbort     = c.md_abort;
  assign oState       = st;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for the stall/flush sequencer.
// Two instances: default timeout and a short timeout of 4.
module tb_pipeline_hazard_ctrl;

  localparam logic [9:0] C_NONE = 10'b0000000000;
  localparam logic [9:0] C_LU   = 10'b1101000000;
  localparam logic [9:0] C_WAIT = 10'b1110100000;
  localparam logic [9:0] C_WTAB = 10'b1110100001;
  localparam logic [9:0] C_ST   = 10'b0000000010;
  localparam logic [9:0] C_FL   = 10'b0000011100;
  localparam logic [9:0] C_FLAB = 10'b0000011101;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1, rs2, rd;
  logic       u1, u2, mr, md, redir, done;

  wire [9:0]  ctl_a, ctl_b;
  wire [1:0]  st_a, st_b;
  wire [31:0] sc_a, fc_a, sc_b, fc_b;
  wire        err_a, err_b;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  typedef struct {
    string       tag;
    logic        b;
    logic [9:0]  ctl;
    logic [1:0]  st;
    logic [31:0] sc;
    logic [31:0] fc;
    logic        err;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.CNT_W(32), .MD_TIMEOUT(64)) dut (
    .iCLK(clk), .iRST(rst),
    .iIF_ID_rs1(rs1), .iIF_ID_rs2(rs2),
    .iUsesRs1(u1), .iUsesRs2(u2),
    .iID_EX_rd(rd), .iID_EX_MemRead(mr),
    .iID_EX_MulDiv(md), .iRedirect(redir), .iMdDone(done),
    .oHoldPC(ctl_a[9]), .oHoldIFID(ctl_a[8]), .oHoldIDEX(ctl_a[7]),
    .oBubbleIDEX(ctl_a[6]), .oBubbleEXMEM(ctl_a[5]),
    .oFlushIFID(ctl_a[4]), .oFlushIDEX(ctl_a[3]),
    .oFlushEXMEM(ctl_a[2]), .oMdStart(ctl_a[1]), .oMdAbort(ctl_a[0]),
    .oMdErr(err_a), .oState(st_a),
    .oStallCnt(sc_a), .oFlushCnt(fc_a)
  );

  pipeline_hazard_ctrl #(.CNT_W(32), .MD_TIMEOUT(4)) dut4 (
    .iCLK(clk), .iRST(rst),
    .iIF_ID_rs1(rs1), .iIF_ID_rs2(rs2),
    .iUsesRs1(u1), .iUsesRs2(u2),
    .iID_EX_rd(rd), .iID_EX_MemRead(mr),
    .iID_EX_MulDiv(md), .iRedirect(redir), .iMdDone(done),
    .oHoldPC(ctl_b[9]), .oHoldIFID(ctl_b[8]), .oHoldIDEX(ctl_b[7]),
    .oBubbleIDEX(ctl_b[6]), .oBubbleEXMEM(ctl_b[5]),
    .oFlushIFID(ctl_b[4]), .oFlushIDEX(ctl_b[3]),
    .oFlushEXMEM(ctl_b[2]), .oMdStart(ctl_b[1]), .oMdAbort(ctl_b[0]),
    .oMdErr(err_b), .oState(st_b),
    .oStallCnt(sc_b), .oFlushCnt(fc_b)
  );

  task automatic set(input logic m_r, input logic [4:0] r_d,
                     input logic [4:0] s1, input logic a1,
                     input logic [4:0] s2, input logic a2,
                     input logic m_d, input logic rdr, input logic dn);
    mr = m_r; rd = r_d;
    rs1 = s1; u1 = a1;
    rs2 = s2; u2 = a2;
    md = m_d; redir = rdr; done = dn;
  endtask

  task automatic idle();
    set(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic cmp(input string tag, input string fld,
                     input logic [31:0] o, input logic [31:0] e);
    n_chk++;
    assert (o === e) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, o, e);
    end
  endtask

  task automatic push(input string tag, input logic b,
                      input logic [9:0] c, input logic [1:0] s,
                      input int sc, input int fc, input logic er);
    exp_t e;
    e.tag = tag; e.b = b; e.ctl = c; e.st = s;
    e.sc = 32'(sc); e.fc = 32'(fc); e.err = er;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    e = sb.pop_front();
    if (e.b) begin
      cmp(e.tag, "ctl", 32'(ctl_b), 32'(e.ctl));
      cmp(e.tag, "st",  32'(st_b),  32'(e.st));
      cmp(e.tag, "stall", sc_b, e.sc);
      cmp(e.tag, "flush", fc_b, e.fc);
      cmp(e.tag, "err", 32'(err_b), 32'(e.err));
    end else begin
      cmp(e.tag, "ctl", 32'(ctl_a), 32'(e.ctl));
      cmp(e.tag, "st",  32'(st_a),  32'(e.st));
      cmp(e.tag, "stall", sc_a, e.sc);
      cmp(e.tag, "flush", fc_a, e.fc);
      cmp(e.tag, "err", 32'(err_a), 32'(e.err));
    end
  endtask

  task automatic step(input string tag, input logic b,
                      input logic [9:0] c, input logic [1:0] s,
                      input int sc, input int fc, input logic er);
    push(tag, b, c, s, sc, fc, er);
    @(negedge clk);
    pop_check();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    step("reset", 0, C_NONE, 2'd0, 0, 0, 1'b0);

    set(1'b1, 5'd5, 5'd5, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    step("lu_rs1", 0, C_LU, 2'd0, 0, 0, 1'b0);
    idle();
    step("lu_after", 0, C_NONE, 2'd0, 1, 0, 1'b0);

    set(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("lu_x0", 0, C_NONE, 2'd0, 1, 0, 1'b0);
    set(1'b1, 5'd7, 5'd3, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    step("lu_nors2", 0, C_NONE, 2'd0, 1, 0, 1'b0);
    set(1'b1, 5'd7, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    step("lu_rs2", 0, C_LU, 2'd0, 1, 0, 1'b0);

    idle(); md = 1'b1;
    step("md_start", 0, C_ST, 2'd0, 2, 0, 1'b0);
    for (int i = 0; i < 5; i++)
      step("md_wait", 0, C_WAIT, 2'd1, 2 + i, 0, 1'b0);
    done = 1'b1;
    step("md_done", 0, C_NONE, 2'd1, 7, 0, 1'b0);
    done = 1'b0;
    step("md_drain", 0, C_NONE, 2'd2, 7, 0, 1'b0);
    md = 1'b0;
    step("md_run", 0, C_NONE, 2'd0, 7, 0, 1'b0);

    md = 1'b1;
    step("rd_start", 0, C_ST, 2'd0, 7, 0, 1'b0);
    step("rd_w1", 0, C_WAIT, 2'd1, 7, 0, 1'b0);
    step("rd_w2", 0, C_WAIT, 2'd1, 8, 0, 1'b0);
    redir = 1'b1;
    step("rd_w3", 0, C_FLAB, 2'd1, 9, 0, 1'b0);
    idle();
    step("rd_run", 0, C_NONE, 2'd0, 9, 1, 1'b0);

    md = 1'b1;
    step("rdd_start", 0, C_ST, 2'd0, 9, 1, 1'b0);
    step("rdd_w1", 0, C_WAIT, 2'd1, 9, 1, 1'b0);
    redir = 1'b1; done = 1'b1;
    step("rdd_both", 0, C_FLAB, 2'd1, 10, 1, 1'b0);
    idle();
    step("rdd_run", 0, C_NONE, 2'd0, 10, 2, 1'b0);

    set(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("rd_lu", 0, C_FL, 2'd0, 10, 2, 1'b0);
    set(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    step("rd_md", 0, C_FL, 2'd0, 10, 3, 1'b0);
    idle(); done = 1'b1;
    step("done_run", 0, C_NONE, 2'd0, 10, 4, 1'b0);

    idle(); rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; md = 1'b1;
    step("to_start", 1, C_ST, 2'd0, 0, 0, 1'b0);
    for (int i = 0; i < 3; i++)
      step("to_wait", 1, C_WAIT, 2'd1, i, 0, 1'b0);
    step("to_hit", 1, C_WTAB, 2'd1, 3, 0, 1'b0);
    md = 1'b0;
    step("to_err", 1, C_NONE, 2'd0, 4, 0, 1'b1);
    step("to_sticky", 1, C_NONE, 2'd0, 4, 0, 1'b1);
    rst = 1'b0;
    step("to_rst_in", 1, C_NONE, 2'd0, 4, 0, 1'b1);
    rst = 1'b1;
    step("to_cleared", 1, C_NONE, 2'd0, 0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
